ps2_spectrum_keymatrix: RTL and testbench
=========================================

// Module: ps2_spectrum_keymatrix
// PURPOSE
//  Consumes the byte stream from the PS/2 receiver (scan byte + one-clock strobe).
//  Decodes set-2 make/break sequences, including the E0/F0/E1 prefixes.
//  Maintains the 8x5 ZX Spectrum key matrix and answers ULA port-FE reads.
//  The ULA drives row_sel from A[15:8].
// PARAMETERS
//  PREFIX_TIMEOUT  56000  clks before a stalled prefix state reverts to IDLE (2 ms @ 28 MHz)
//  TIMEOUT_BITS    16     width of prefix watchdog counter
// PORTS
//  clk        in   1  system clock
//  reset_n    in   1  asynchronous, active-low reset
//  scan_valid in   1  one-clk strobe: new byte on scan_code (receiver interrupt)
//  scan_code  in   8  received PS/2 byte, valid only with scan_valid
//  row_sel    in   8  active-low row selects, bit r = A[8+r]
//  cols       out  5  active-low column data, registered; bit0 = outermost key
// BEHAVIOUR
//  Reset: FSM=IDLE, all 40 direct bits and 5 composite flags cleared, cols=5'b11111, counters 0.
//  Decode FSM, advances only on scan_valid:
//   IDLE:  E0->EXT; F0->REL; E1->SKIP(cnt=7); other bytes are a make, key code (ext=0).
//   EXT:   F0->EXTREL; E0/E1 are ignored and the state is held; other bytes are a make, key code (ext=1).
//   REL:   any byte except E0/E1 is a break (ext=0), then ->IDLE.
//   EXTREL: any byte is a break (ext=1), then ->IDLE.
//   SKIP:  each byte decrements cnt; ->IDLE when cnt reaches 0 (Pause key sequence is discarded).
//   Unmapped codes (incl. AA, FA, EE, fake-shift E0 12) change no matrix bit but complete the sequence ->IDLE.
//  Codes 00/FF (buffer overrun) in any state: clear all direct and composite bits, ->IDLE.
//  Watchdog:
//   - Counter runs while the state is not IDLE; it clears on each scan_valid.
//   - Reaching PREFIX_TIMEOUT-1 forces IDLE.
//   - If scan_valid arrives on the expiry cycle, the byte is processed in the old state.
//  Direct map (row: col0..col4 scan codes), pressed bit = 1 on make, 0 on break:
//   r0 CS,Z,X,C,V = 12|59,1A,22,21,2A   r1 A,S,D,F,G = 1C,1B,23,2B,34
//   r2 Q,W,E,R,T = 15,1D,24,2D,2C       r3 1..5 = 16,1E,26,25,2E
//   r4 0,9,8,7,6 = 45,46,3E,3D,36       r5 P,O,I,U,Y = 4D,44,43,3C,35
//   r6 ENT,L,K,J,H = 5A,4B,42,3B,33     r7 SP,SS,M,N,B = 29,14|E0 14,3A,31,32
//   LShift and RShift have separate bits, ORed into CS.
//   LCtrl and RCtrl have separate bits, ORed into SS.
//   E0 5A (keypad Enter) maps to ENT.
//  Composite flags (each sets CS plus one key; never touch the direct bits):
//   66 Bksp -> CS+0
//   E0 6B left -> CS+5
//   E0 72 down -> CS+6
//   E0 75 up -> CS+7
//   E0 74 right -> CS+8
//  Releasing a composite never releases a physically held Shift, and vice versa.
//  Effective pressed[r][c] = direct | composite contributions.
//  cols[c] <= ~OR over r with row_sel[r]==0 of pressed[r][c].
//   - Registered every clk, so the result reflects row_sel one clk later.
//   - A matrix update from a byte is visible on cols two clks after scan_valid.
//   - row_sel=FF gives cols=11111.
//   - row_sel=00 ORs all eight rows.
//  A repeated make (typematic) is idempotent. A break of a key not held is harmless.
//  reset_n asserted mid-sequence discards the partial prefix and clears the matrix immediately.
// TESTING
//  - Reset; row_sel=FE -> cols=11111; state IDLE.
//  - Send 1A: row_sel=FE -> cols=11101.
//    Then send F0,1A: cols=11111.
//    Run typematic 1A x5 followed by a single F0 1A: cols=11111.
//  - Hold 12 (LShift), then send E0 6B: row_sel=F7 -> 01111, FE -> 11110.
//    Then send E0 F0 6B: FE still 11110 (shift held), F7=11111.
//  - Send E0 with no follow-up for PREFIX_TIMEOUT clks, then 1A -> Z pressed (make, not break).
//    Send F0 alone, time out, then 29 -> Space pressed.
//  - Send the Pause sequence E1 14 77 E1 F0 14 F0 77, then 15: only Q pressed.
//    Ctrl/SS must not toggle.
//  - Press Z, A, Q, then send 00: all rows 11111.
//    Press 1A and 1C with row_sel=FC -> cols=11100 (OR of r0 and r1).

Source files
------------

// File: rtl/ps2_spectrum_keymatrix.sv
// ps2_spectrum_keymatrix
//   Turns PS/2 set-2 scan bytes into the ZX Spectrum 8x5 key matrix and answers
//   ULA port-FE reads.
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   scan_valid one-clk strobe, new byte on scan_code
//   scan_code  received PS/2 byte
//   row_sel    active-low row selects (bit r = A[8+r])
//   cols       active-low column data, registered; bit0 = outermost key
module ps2_spectrum_keymatrix #(
  parameter int PREFIX_TIMEOUT = 56000,
  parameter int TIMEOUT_BITS   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic [7:0] row_sel,
  output logic [4:0] cols
);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_REL, S_EXTREL, S_SKIP} state_t;
  typedef enum logic [2:0] {K_NONE, K_DIR, K_LSH, K_RSH, K_LCT, K_RCT, K_CMP} kind_t;
  typedef struct packed {
    kind_t      kind;
    logic [5:0] idx;   // row*5+col for K_DIR, composite number for K_CMP
  } key_t;

  // {ext, code} -> matrix target. Shift/Ctrl keep their own bits so that two
  // physical keys (or a composite) on the same matrix position stay independent.
  function automatic key_t decode(input logic ext, input logic [7:0] code);
    key_t k;
    k.kind = K_DIR;
    k.idx  = '0;
    case ({ext, code})
      9'h012: k.kind = K_LSH;
      9'h059: k.kind = K_RSH;
      9'h01A: k.idx = 6'd1;   9'h022: k.idx = 6'd2;   9'h021: k.idx = 6'd3;   9'h02A: k.idx = 6'd4;
      9'h01C: k.idx = 6'd5;   9'h01B: k.idx = 6'd6;   9'h023: k.idx = 6'd7;   9'h02B: k.idx = 6'd8;
      9'h034: k.idx = 6'd9;
      9'h015: k.idx = 6'd10;  9'h01D: k.idx = 6'd11;  9'h024: k.idx = 6'd12;  9'h02D: k.idx = 6'd13;
      9'h02C: k.idx = 6'd14;
      9'h016: k.idx = 6'd15;  9'h01E: k.idx = 6'd16;  9'h026: k.idx = 6'd17;  9'h025: k.idx = 6'd18;
      9'h02E: k.idx = 6'd19;
      9'h045: k.idx = 6'd20;  9'h046: k.idx = 6'd21;  9'h03E: k.idx = 6'd22;  9'h03D: k.idx = 6'd23;
      9'h036: k.idx = 6'd24;
      9'h04D: k.idx = 6'd25;  9'h044: k.idx = 6'd26;  9'h043: k.idx = 6'd27;  9'h03C: k.idx = 6'd28;
      9'h035: k.idx = 6'd29;
      9'h05A, 9'h15A: k.idx = 6'd30;
      9'h04B: k.idx = 6'd31;  9'h042: k.idx = 6'd32;  9'h03B: k.idx = 6'd33;  9'h033: k.idx = 6'd34;
      9'h029: k.idx = 6'd35;
      9'h014: k.kind = K_LCT;
      9'h114: k.kind = K_RCT;
      9'h03A: k.idx = 6'd37;  9'h031: k.idx = 6'd38;  9'h032: k.idx = 6'd39;
      9'h066: begin k.kind = K_CMP; k.idx = 6'd0; end  // Bksp  = CS+0
      9'h16B: begin k.kind = K_CMP; k.idx = 6'd1; end  // left  = CS+5
      9'h172: begin k.kind = K_CMP; k.idx = 6'd2; end  // down  = CS+6
      9'h175: begin k.kind = K_CMP; k.idx = 6'd3; end  // up    = CS+7
      9'h174: begin k.kind = K_CMP; k.idx = 6'd4; end  // right = CS+8
      default: k.kind = K_NONE;
    endcase
    return k;
  endfunction

  state_t                  state_q, state_d;
  logic [2:0]              skip_q, skip_d;
  logic [TIMEOUT_BITS-1:0] wd_q;
  logic                    wd_expired;
  logic                    do_make, do_brk, do_clr, ext;
  key_t                    key;

  logic [39:0]             dir_q;  // bits 0 (CS) and 36 (SS) are derived, never set directly
  logic [3:0]              mod_q;  // {rctrl, lctrl, rshift, lshift}
  logic [4:0]              cmp_q;
  logic [7:0][4:0]         pressed;
  logic [4:0]              hit;
  logic [4:0]              cols_q;

  assign wd_expired = (state_q != S_IDLE) && (wd_q == TIMEOUT_BITS'(PREFIX_TIMEOUT - 1));
  assign key        = decode(ext, scan_code);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // A byte on the expiry cycle wins: it is decoded in the old state.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    do_make = 1'b0;
    do_brk  = 1'b0;
    do_clr  = 1'b0;
    ext     = 1'b0;
    if (scan_valid) begin
      if (scan_code == 8'h00 || scan_code == 8'hFF) begin
        do_clr  = 1'b1;
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (scan_code == 8'hE0)      state_d = S_EXT;
            else if (scan_code == 8'hF0) state_d = S_REL;
            else if (scan_code == 8'hE1) begin
              state_d = S_SKIP;
              skip_d  = 3'd7;
            end else do_make = 1'b1;
          end
          S_EXT: begin
            ext = 1'b1;
            if (scan_code == 8'hF0) state_d = S_EXTREL;
            else if (scan_code != 8'hE0 && scan_code != 8'hE1) begin
              do_make = 1'b1;
              state_d = S_IDLE;
            end
          end
          S_REL: begin
            if (scan_code != 8'hE0 && scan_code != 8'hE1) begin
              do_brk  = 1'b1;
              state_d = S_IDLE;
            end
          end
          S_EXTREL: begin
            ext     = 1'b1;
            do_brk  = 1'b1;
            state_d = S_IDLE;
          end
          S_SKIP: begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (wd_expired) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            wd_q <= '0;
    else if (scan_valid || state_q == S_IDLE) wd_q <= '0;
    else if (wd_expired)                      wd_q <= '0;
    else                                      wd_q <= wd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q <= '0;
      mod_q <= '0;
      cmp_q <= '0;
    end else if (do_clr) begin
      dir_q <= '0;
      mod_q <= '0;
      cmp_q <= '0;
    end else if (do_make || do_brk) begin
      case (key.kind)
        K_DIR:   dir_q[key.idx]      <= do_make;
        K_LSH:   mod_q[0]            <= do_make;
        K_RSH:   mod_q[1]            <= do_make;
        K_LCT:   mod_q[2]            <= do_make;
        K_RCT:   mod_q[3]            <= do_make;
        K_CMP:   cmp_q[key.idx[2:0]] <= do_make;
        default: ;
      endcase
    end
  end

  always_comb begin
    pressed        = dir_q;
    pressed[0][0]  = (|mod_q[1:0]) | (|cmp_q);
    pressed[7][1]  = |mod_q[3:2];
    pressed[4][0] |= cmp_q[0];
    pressed[3][4] |= cmp_q[1];
    pressed[4][4] |= cmp_q[2];
    pressed[4][3] |= cmp_q[3];
    pressed[4][2] |= cmp_q[4];
  end

  always_comb begin
    hit = '0;
    for (int r = 0; r < 8; r++)
      if (!row_sel[r]) hit |= pressed[r];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cols_q <= 5'b11111;
    else          cols_q <= ~hit;
  end

  assign cols = cols_q;

endmodule

// File: tb/tb_ps2_spectrum_keymatrix.sv
module tb_ps2_spectrum_keymatrix;
  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic [7:0] row_sel = 8'h00;
  logic [4:0] cols;

  int n_cmp = 0;
  int n_err = 0;

  ps2_spectrum_keymatrix #(.PREFIX_TIMEOUT(TO), .TIMEOUT_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n), .scan_valid(scan_valid),
    .scan_code(scan_code), .row_sel(row_sel), .cols(cols)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_valid = 1'b1;
    scan_code  = b;
    @(negedge clk);
    scan_valid = 1'b0;
    scan_code  = 8'h00;
  endtask

  task automatic look(input string tag, input logic [7:0] rs, input logic [4:0] exp);
    @(negedge clk);
    row_sel = rs;
    repeat (2) @(negedge clk);
    chk(tag, cols, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset
    idle(3);
    chk("rst_all_rows", cols, 5'b11111);
    reset_n = 1'b1;
    look("rst_r0", 8'hFE, 5'b11111);

    // plain make / break / typematic
    send(8'h1A);
    look("z_make", 8'hFE, 5'b11101);
    look("z_rs_ff", 8'hFF, 5'b11111);
    look("z_rs_00", 8'h00, 5'b11101);
    send(8'hF0); send(8'h1A);
    look("z_break", 8'hFE, 5'b11111);
    for (int i = 0; i < 5; i++) send(8'h1A);
    look("z_typematic", 8'hFE, 5'b11101);
    send(8'hF0); send(8'h1A);
    look("z_typ_break", 8'hFE, 5'b11111);

    // shift held across composite left
    send(8'h12);
    look("lsh_make", 8'hFE, 5'b11110);
    send(8'hE0); send(8'h6B);
    look("left_r3", 8'hF7, 5'b01111);
    look("left_r0", 8'hFE, 5'b11110);
    send(8'hE0); send(8'hF0); send(8'h6B);
    look("left_rel_r0", 8'hFE, 5'b11110);
    look("left_rel_r3", 8'hF7, 5'b11111);
    send(8'hF0); send(8'h12);
    look("lsh_break", 8'hFE, 5'b11111);

    // fake shift and right ctrl
    send(8'hE0); send(8'h12);
    look("fake_shift", 8'hFE, 5'b11111);
    send(8'hE0); send(8'h14);
    look("rctrl_ss", 8'h7F, 5'b11101);
    send(8'h00);
    look("rctrl_clr", 8'h7F, 5'b11111);

    // backspace composite
    send(8'h66);
    look("bksp_r4", 8'hEF, 5'b11110);
    look("bksp_r0", 8'hFE, 5'b11110);
    send(8'hF0); send(8'h66);
    look("bksp_rel", 8'h00, 5'b11111);

    // watchdog
    send(8'hE0);
    idle(TO + 50);
    send(8'h1A);
    look("ext_timeout", 8'hFE, 5'b11101);
    send(8'hF0); send(8'h1A);
    send(8'hF0);
    idle(TO + 50);
    send(8'h29);
    look("rel_timeout", 8'h7F, 5'b11110);
    send(8'hF0); send(8'h29);
    look("sp_break", 8'h7F, 5'b11111);
    send(8'hE0);
    idle(TO / 2);
    send(8'h75);
    look("ext_in_time_r4", 8'hEF, 5'b10111);
    look("ext_in_time_r0", 8'hFE, 5'b11110);
    send(8'hE0); send(8'hF0); send(8'h75);
    look("up_rel", 8'h00, 5'b11111);

    // pause sequence discarded
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h15);
    look("pause_q", 8'hFB, 5'b11110);
    look("pause_ss", 8'h7F, 5'b11111);
    look("pause_all", 8'h00, 5'b11110);

    // overrun clear
    send(8'h1A); send(8'h1C);
    send(8'h00);
    look("overrun_clr", 8'h00, 5'b11111);

    // multi-row OR
    send(8'h1A); send(8'h1C);
    look("rows_or", 8'hFC, 5'b11100);

    // reset mid-prefix: F0 discarded, next 1A is a make
    send(8'hF0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid", cols, 5'b11111);
    reset_n = 1'b1;
    send(8'h1A);
    look("rst_prefix_gone", 8'hFC, 5'b11101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
